id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register of the five-stage RV32I core, with integrated load-use hazard detection. It captures the instruction decoder's control bits, together with the ID-stage operands and register indices, at each clock edge. It inserts a bubble on branch/jump flush or on a load-use hazard, and freezes on a memory stall. Its `ex_*` outputs feed the ALU control, forwarding unit and EX stage; `hazard_stall` goes back to the PC and IF/ID registers.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REGW`, 5, register index width

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  ID slot holds a real instruction
- `id_jalr, id_jal, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite`  in  1 each  decoder control bits
- `id_aluop`  in  2  decoder ALU op class
- `id_funct`  in  4  {instr[30], funct3}
- `id_pc, id_rs1_data, id_rs2_data, id_imm`  in  XLEN each  ID operands
- `id_rs1, id_rs2, id_rd`  in  REGW each  register indices
- `flush`  in  1  mispredict/redirect from EX; kill ID instruction
- `mem_stall`  in  1  cache miss; global pipeline freeze
- `ex_valid` plus `ex_*` mirrors of every `id_*` input  out  same widths  registered EX-stage values
- `hazard_stall`  out  1  load-use stall request to PC and IF/ID (combinational)
- `bubble_cnt, flush_cnt`  out  16 each  performance counters (see Configuration)

## Operation
- `uses_rs1 = !id_jal`.
- `uses_rs2 = (!id_alusrc && !id_jal) || id_memwrite`.
- `load_use` = `id_valid && ex_valid && ex_memread && ex_rd != 0 && ((ex_rd == id_rs1 && uses_rs1) || (ex_rd == id_rs2 && uses_rs2))`.
- `hazard_stall = load_use && !flush`. A flush kills the dependent instruction, so no stall is needed.
- Per-edge update, in priority order:
  1. `mem_stall=1`: all registers hold (including counters).
  2. `flush=1`: bubble.
  3. `load_use=1`: bubble. The ID instruction is re-presented next cycle because IF/ID holds.
  4. Otherwise: capture all `id_*` into `ex_*`, and `ex_valid <= id_valid`.
- Bubble: `ex_valid` and all control outputs (`jalr`, `jal`, `branch`, `memread`, `memtoreg`, `memwrite`, `alusrc`, `regwrite`, `aluop`) become 0. All data and index outputs also become 0.
- Capture with `id_valid=0`: controls are captured as presented and `ex_valid=0`. Downstream qualifies side effects with `ex_valid`.
- `ex_rd` equal to 0 never triggers a hazard.

## Timing
- Reset (`rst_n=0`, asynchronous, any cycle): every registered output is 0, including `ex_valid` and the counters. The first capture happens on the first rising edge after `rst_n` deasserts.
- Latency: one cycle, ID to EX.
- `hazard_stall` depends on the current `ex_*` and `id_*`/`flush` in the same cycle, with no register. A load-use costs exactly one bubble: on the next cycle `ex_memread=0`, so the stall clears.
- `mem_stall` together with `load_use`: `hazard_stall` stays asserted and the registers hold. The bubble is inserted on the first edge after `mem_stall` drops.
- `flush` together with `load_use`: one bubble, and `hazard_stall=0`.
- Back-to-back flushes produce consecutive bubbles.

## Configuration
- `ID_EX_PERF_CNT_EN` defined:
  - `bubble_cnt` increments on each edge that inserts a bubble due to `load_use`.
  - `flush_cnt` increments on each edge that inserts a bubble due to `flush`.
  - Both saturate at 16'hFFFF.
  - Both hold during `mem_stall`.
  - Both are reset to 0.
- `ID_EX_PERF_CNT_EN` undefined: no counter registers are built; both ports are tied to 16'h0000.

## Test plan
- Reset mid-run: with `ex_valid=1` and `ex_regwrite=1`, pull `rst_n` low between edges → all outputs read 0 immediately, before any clock edge.
- Normal capture: present R-type `add x3,x1,x2` (regwrite=1, aluop=00, `id_rs1_data`=5, `id_rs2_data`=7, `id_rd`=3, `id_valid`=1) → after one edge: `ex_regwrite=1`, `ex_rs1_data=5`, `ex_rs2_data=7`, `ex_rd=3`, `ex_valid=1`.
- Load-use, rs2 path: EX holds `lw x5` (`ex_memread=1`, `ex_rd=5`); ID presents `add x6,x1,x5` → `hazard_stall=1` that cycle; next edge bubble (`ex_valid=0`, `ex_regwrite=0`, `bubble_cnt=1` when enabled); following edge captures the `add`.
- Hazard exemptions:
  - ID `addi x6,x5,1` (alusrc=1) with `ex_rd=5` → rs1 hazard, stall=1.
  - ID `jal` with `id_rs1=5` → stall=0.
  - `lw x0` in EX → stall=0.
- Flush priority: `flush=1` together with a load-use condition → `hazard_stall=0`; next edge bubble with `flush_cnt=1`, `bubble_cnt` unchanged.
- Freeze: `mem_stall=1` for 3 cycles while `flush=1` → `ex_*` and counters unchanged. After `mem_stall` drops with `flush` still 1, the next edge inserts a bubble.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection; ID_EX_PERF_CNT_EN adds bubble/flush counters.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic            id_jalr,
  input  logic            id_jal,
  input  logic            id_branch,
  input  logic            id_memread,
  input  logic            id_memtoreg,
  input  logic            id_memwrite,
  input  logic            id_alusrc,
  input  logic            id_regwrite,
  input  logic [1:0]      id_aluop,
  input  logic [3:0]      id_funct,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic            flush,
  input  logic            mem_stall,
  output logic            ex_valid,
  output logic            ex_jalr,
  output logic            ex_jal,
  output logic            ex_branch,
  output logic            ex_memread,
  output logic            ex_memtoreg,
  output logic            ex_memwrite,
  output logic            ex_alusrc,
  output logic            ex_regwrite,
  output logic [1:0]      ex_aluop,
  output logic [3:0]      ex_funct,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [REGW-1:0] ex_rs1,
  output logic [REGW-1:0] ex_rs2,
  output logic [REGW-1:0] ex_rd,
  output logic            hazard_stall,
  output logic [15:0]     bubble_cnt,
  output logic [15:0]     flush_cnt
);
  typedef struct packed {
    logic            valid, jalr, jal, branch, memread, memtoreg, memwrite, alusrc, regwrite;
    logic [1:0]      aluop;
    logic [3:0]      funct;
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
    logic [REGW-1:0] rs1, rs2, rd;
  } stage_t;
  stage_t id, ex;
  logic uses_rs1, uses_rs2, load_use;
  assign id = {id_valid, id_jalr, id_jal, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc,
               id_regwrite, id_aluop, id_funct, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd};
  assign {ex_valid, ex_jalr, ex_jal, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc,
          ex_regwrite, ex_aluop, ex_funct, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd} = ex;
  assign uses_rs1 = !id_jal;
  assign uses_rs2 = (!id_alusrc && !id_jal) || id_memwrite;
  assign load_use = id_valid && ex.valid && ex.memread && ex.rd != '0 &&
                    ((ex.rd == id_rs1 && uses_rs1) || (ex.rd == id_rs2 && uses_rs2));
  assign hazard_stall = load_use && !flush;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ex <= '0;
    else if (!mem_stall) ex <= (flush || load_use) ? '0 : id;
`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (!mem_stall) begin
      bubble_cnt <= bubble_cnt + {15'd0, hazard_stall && bubble_cnt != 16'hFFFF};
      flush_cnt  <= flush_cnt + {15'd0, flush && flush_cnt != 16'hFFFF};
    end
`else
  assign bubble_cnt = 16'h0000;
  assign flush_cnt  = 16'h0000;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: random and directed checks of id_ex_stage against a cycle-level reference model.
module tb_id_ex_stage;
  localparam int W = 158;
  logic clk = 0, rst_n = 0;
  logic id_valid, id_jalr, id_jal, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
  logic [1:0] id_aluop;
  logic [3:0] id_funct;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic flush, mem_stall;
  logic ex_valid, ex_jalr, ex_jal, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
  logic [1:0] ex_aluop;
  logic [3:0] ex_funct;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic hazard_stall;
  logic [15:0] bubble_cnt, flush_cnt;
  logic [W-1:0] m_ex;
  int m_bub, m_fl, n_vec, n_err;
  bit lu_q;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_jalr(id_jalr), .id_jal(id_jal),
    .id_branch(id_branch), .id_memread(id_memread), .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_aluop(id_aluop), .id_funct(id_funct),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .mem_stall(mem_stall),
    .ex_valid(ex_valid), .ex_jalr(ex_jalr), .ex_jal(ex_jal), .ex_branch(ex_branch),
    .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
    .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop), .ex_funct(ex_funct), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] id_vec();
    return {id_valid, id_jalr, id_jal, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc,
            id_regwrite, id_aluop, id_funct, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd};
  endfunction

  function automatic logic [W-1:0] ex_vec();
    return {ex_valid, ex_jalr, ex_jal, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc,
            ex_regwrite, ex_aluop, ex_funct, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd};
  endfunction

  // Model EX slot fields: valid is bit 157, memread bit 153, rd bits 4:0.
  function automatic bit model_lu();
    logic [4:0] rd = m_ex[4:0];
    bit u1 = !id_jal;
    bit u2 = (!id_alusrc && !id_jal) || id_memwrite;
    return id_valid && m_ex[157] && m_ex[153] && rd != 0 && ((rd == id_rs1 && u1) || (rd == id_rs2 && u2));
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_cnt(input int c);
`ifdef ID_EX_PERF_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic check_outputs();
    chk("ex", ex_vec(), m_ex);
    chk("bubble_cnt", bubble_cnt, exp_cnt(m_bub));
    chk("flush_cnt", flush_cnt, exp_cnt(m_fl));
  endtask

  task automatic cycle();
    #1;
    lu_q = model_lu();
    chk("stall", hazard_stall, lu_q && !flush);
    @(posedge clk);
    if (!mem_stall) begin
      if (flush) begin m_ex = '0; if (m_fl < 65535) m_fl++; end
      else if (lu_q) begin m_ex = '0; if (m_bub < 65535) m_bub++; end
      else m_ex = id_vec();
    end
    #1;
    check_outputs();
  endtask

  task automatic clear_id();
    {id_valid, id_jalr, id_jal, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite} = '0;
    id_aluop = 0; id_funct = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; flush = 0; mem_stall = 0;
  endtask

  task automatic rand_id();
    {id_jalr, id_jal, id_branch, id_memtoreg, id_memwrite, id_alusrc, id_regwrite} = 7'($urandom);
    id_valid = $urandom_range(0, 7) != 0;
    id_memread = $urandom_range(0, 1);
    id_aluop = 2'($urandom); id_funct = 4'($urandom);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
    flush = $urandom_range(0, 7) == 0;
    mem_stall = $urandom_range(0, 5) == 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    m_ex = '0; m_bub = 0; m_fl = 0;
    check_outputs();
    #2 rst_n = 1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; m_ex = '0; m_bub = 0; m_fl = 0;
    clear_id();
    #12 check_outputs();
    rst_n = 1;
    // add x3,x1,x2
    id_valid = 1; id_regwrite = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 3; id_rs1_data = 5; id_rs2_data = 7;
    cycle();
    chk("add_rw", {ex_valid, ex_regwrite, ex_rd}, {2'b11, 5'd3});
    chk("add_data", {ex_rs1_data, ex_rs2_data}, {32'd5, 32'd7});
    do_reset();
    chk("rst_valid", {ex_valid, ex_regwrite}, 0);
    // lw x5 then add x6,x1,x5
    clear_id(); id_valid = 1; id_memread = 1; id_memtoreg = 1; id_alusrc = 1; id_regwrite = 1; id_rd = 5; id_rs1 = 2;
    cycle();
    clear_id(); id_valid = 1; id_regwrite = 1; id_rs1 = 1; id_rs2 = 5; id_rd = 6;
    #1 chk("lu_rs2", hazard_stall, 1);
    cycle();
    chk("lu_bubble", {ex_valid, ex_regwrite}, 0);
    cycle();
    chk("lu_capture", {ex_valid, ex_rd}, {1'b1, 5'd6});
    // lw x5 again, then exemption probes without advancing
    clear_id(); id_valid = 1; id_memread = 1; id_regwrite = 1; id_alusrc = 1; id_rd = 5;
    cycle();
    clear_id(); id_valid = 1; id_alusrc = 1; id_regwrite = 1; id_rs1 = 5; id_rs2 = 9; id_rd = 6;
    #1 chk("addi_rs1", hazard_stall, 1);
    id_jal = 1; id_alusrc = 0; id_rs2 = 0;
    #1 chk("jal_exempt", hazard_stall, 0);
    id_jal = 0; id_alusrc = 1; flush = 1;
    #1 chk("flush_nostall", hazard_stall, 0);
    cycle();
    chk("flush_bubble", ex_valid, 0);
    // lw x0 never stalls
    clear_id(); id_valid = 1; id_memread = 1; id_alusrc = 1; id_rd = 0;
    cycle();
    clear_id(); id_valid = 1; id_rs1 = 0; id_rs2 = 0;
    #1 chk("lw_x0", hazard_stall, 0);
    cycle();
    // freeze with flush pending
    clear_id(); id_valid = 1; id_regwrite = 1; id_rd = 7; id_pc = 32'h100;
    cycle();
    flush = 1; mem_stall = 1;
    repeat (3) cycle();
    chk("freeze_hold", {ex_valid, ex_rd}, {1'b1, 5'd7});
    mem_stall = 0;
    cycle();
    chk("unfreeze_bubble", ex_valid, 0);
    cycle();
    // random traffic with an occasional asynchronous reset
    for (int i = 0; i < 600; i++) begin
      rand_id();
      cycle();
      if (i % 200 == 150) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
